// File: rtl/player_input.sv
// player_input: per-player keycode decoder, frame-tick aligner and bomb charge/fire/cooldown FSM.
// Define PLAYER_INPUT_AUTOREPEAT_EN to add auto-repeat press pulses for movement and aim actions.
module player_input #(
  parameter int unsigned CHARGE_W        = 6,
  parameter int unsigned MAX_CHARGE      = 63,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_clk,
  input  logic [7:0]          keycode,
  input  logic [63:0]         controls,
  output logic [7:0]          held,
  output logic [7:0]          pressed,
  output logic                charging,
  output logic [CHARGE_W-1:0] charge,
  output logic                fire_valid,
  output logic [CHARGE_W-1:0] fire_power,
  input  logic                fire_ready,
  output logic                cooldown
);

  localparam int unsigned FIRE_IDX = 1;
  localparam int unsigned CNT_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  // Reject parameter sets the datapath cannot represent.
  if ((MAX_CHARGE > (1 << CHARGE_W) - 1) || (REPEAT_PERIOD == 0) || (REPEAT_DELAY > 1024)) begin : g_bad_params
    $error("player_input: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHARGE   = 2'd1,
    S_FIRE     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  logic [2:0]          sync_q;
  logic                tick;
  logic [7:0]          raw;
  logic [7:0]          pressed_d;
  logic                fire_edge;
  state_t              state_q, state_d;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic [CHARGE_W-1:0] power_q, power_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                fire_valid_d, charging_d, cooldown_d;

  // Two-flop synchronizer plus one delay stage; tick is the registered rising edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end

  // A zero keycode never matches, even against an empty (zero) slot.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[i] = (keycode != 8'd0) && (keycode == controls[8*i +: 8]);
    end
  end

  assign fire_edge = raw[FIRE_IDX] & ~held[FIRE_IDX];

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
  localparam int unsigned RPT_TOP = REPEAT_DELAY + REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_TOP + 1);

  logic [7:2][RPT_W-1:0] rpt_q, rpt_d;

  // Counter holds the held-frame count, folding back into the repeat window after each period.
  always_comb begin
    pressed_d = raw & ~held;
    rpt_d     = '0;
    for (int i = 2; i < 8; i++) begin
      if (!raw[i]) begin
        rpt_d[i] = '0;
      end else if (!held[i]) begin
        rpt_d[i] = RPT_W'(1);
      end else if (rpt_q[i] == RPT_W'(RPT_TOP)) begin
        rpt_d[i] = RPT_W'(REPEAT_DELAY + 1);
      end else begin
        rpt_d[i] = rpt_q[i] + RPT_W'(1);
      end
      if (raw[i] && held[i] && (rpt_d[i] == RPT_W'(REPEAT_DELAY + 1))) begin
        pressed_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rpt_q <= '0;
    end else if (tick) begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign pressed_d = raw & ~held;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      held    <= '0;
      pressed <= '0;
    end else if (tick) begin
      held    <= raw;
      pressed <= pressed_d;
    end
  end

  // State register with datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      charge_q   <= '0;
      power_q    <= '0;
      count_q    <= '0;
      fire_valid <= 1'b0;
      charging   <= 1'b0;
      cooldown   <= 1'b0;
    end else begin
      state_q    <= state_d;
      charge_q   <= charge_d;
      power_q    <= power_d;
      count_q    <= count_d;
      fire_valid <= fire_valid_d;
      charging   <= charging_d;
      cooldown   <= cooldown_d;
    end
  end

  // Next state: everything waits for tick except the launch handshake.
  always_comb begin
    state_d  = state_q;
    charge_d = charge_q;
    power_d  = power_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (tick && fire_edge) begin
          state_d  = S_CHARGE;
          charge_d = CHARGE_W'(1);
        end
      end
      S_CHARGE: begin
        if (tick) begin
          if (raw[FIRE_IDX]) begin
            if (charge_q < CHARGE_W'(MAX_CHARGE)) begin
              charge_d = charge_q + CHARGE_W'(1);
            end
          end else begin
            power_d = charge_q;
            state_d = S_FIRE;
          end
        end
      end
      S_FIRE: begin
        if (fire_valid && fire_ready) begin
          state_d  = S_COOLDOWN;
          count_d  = CNT_W'(COOLDOWN_FRAMES);
          charge_d = '0;
        end
      end
      S_COOLDOWN: begin
        if (tick) begin
          if (count_q <= CNT_W'(1)) begin
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    fire_valid_d = 1'b0;
    charging_d   = 1'b0;
    cooldown_d   = 1'b0;
    case (state_d)
      S_CHARGE:   charging_d   = 1'b1;
      S_FIRE:     fire_valid_d = 1'b1;
      S_COOLDOWN: cooldown_d   = 1'b1;
      default:    ;
    endcase
  end

  assign charge     = charge_q;
  assign fire_power = power_q;

endmodule

// File: tb/tb_player_input.sv
// tb_player_input: randomized and directed stimulus for player_input against a frame-level model.
module tb_player_input;

  localparam int unsigned CHARGE_W        = 6;
  localparam int unsigned MAX_CHARGE      = 63;
  localparam int unsigned COOLDOWN_FRAMES = 30;
  localparam int unsigned REPEAT_DELAY    = 20;
  localparam int unsigned REPEAT_PERIOD   = 4;

  // slots 7..0: up, down, left, right, aim-left, aim-right, fire, alt
  localparam logic [63:0] P1 = {8'd26, 8'd22, 8'd4, 8'd7, 8'd20, 8'd8, 8'd30, 8'd31};
  localparam logic [63:0] P2 = {8'd12, 8'd14, 8'd13, 8'd15, 8'd16, 8'd17, 8'd40, 8'd0};

  logic                clk = 1'b0;
  logic                reset_n;
  logic                frame_clk;
  logic [7:0]          keycode;
  logic [63:0]         controls;
  logic [7:0]          held;
  logic [7:0]          pressed;
  logic                charging;
  logic [CHARGE_W-1:0] charge;
  logic                fire_valid;
  logic [CHARGE_W-1:0] fire_power;
  logic                fire_ready;
  logic                cooldown;

  always #10 clk = ~clk;

  player_input #(
    .CHARGE_W(CHARGE_W), .MAX_CHARGE(MAX_CHARGE), .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .controls(controls), .held(held), .pressed(pressed), .charging(charging),
    .charge(charge), .fire_valid(fire_valid), .fire_power(fire_power),
    .fire_ready(fire_ready), .cooldown(cooldown)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference model.
  logic [7:0] m_held, m_pressed;
  int         m_charge, m_power, m_cool_left;
  int         m_hold_n [8];
  bit         m_charging, m_firing, m_cooling;

  function automatic void model_reset();
    m_held = '0; m_pressed = '0;
    m_charge = 0; m_power = 0; m_cool_left = 0;
    m_charging = 0; m_firing = 0; m_cooling = 0;
    for (int i = 0; i < 8; i++) m_hold_n[i] = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (k != 8'd0) && (k == controls[8*i +: 8]);
    if (m_cooling) begin
      m_cool_left = m_cool_left - 1;
      if (m_cool_left <= 0) m_cooling = 0;
    end else if (m_charging) begin
      if (r[1]) begin
        if (m_charge < int'(MAX_CHARGE)) m_charge = m_charge + 1;
      end else begin
        m_power = m_charge; m_charging = 0; m_firing = 1;
      end
    end else if (!m_firing && r[1] && !m_held[1]) begin
      m_charging = 1; m_charge = 1;
    end
    for (int i = 0; i < 8; i++) m_hold_n[i] = r[i] ? m_hold_n[i] + 1 : 0;
    m_pressed = r & ~m_held;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
    for (int i = 2; i < 8; i++) begin
      if (m_hold_n[i] > int'(REPEAT_DELAY) &&
          ((m_hold_n[i] - int'(REPEAT_DELAY) - 1) % int'(REPEAT_PERIOD)) == 0)
        m_pressed[i] = 1'b1;
    end
`endif
    m_held = r;
  endfunction

  task automatic check_all();
    check("held", 64'(held), 64'(m_held));
    check("pressed", 64'(pressed), 64'(m_pressed));
    check("charging", 64'(charging), 64'(m_charging));
    check("charge", 64'(charge), 64'(m_charge));
    check("fire_valid", 64'(fire_valid), 64'(m_firing));
    check("fire_power", 64'(fire_power), 64'(m_power));
    check("cooldown", 64'(cooldown), 64'(m_cooling));
  endtask

  // One frame: tick lands 3 clk after frame_clk rises, outputs update on the next clk.
  task automatic frame(input logic [7:0] k);
    @(negedge clk);
    keycode   = k;
    frame_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("held_before_update", 64'(held), 64'(m_held));
    model_frame(k);
    @(posedge clk);
    #1;
    check_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic accept();
    @(negedge clk);
    fire_ready = 1'b1;
    check("fire_valid_before_accept", 64'(fire_valid), 64'(m_firing));
    @(posedge clk);
    #1;
    if (m_firing) begin
      m_firing = 0; m_cooling = 1; m_cool_left = int'(COOLDOWN_FRAMES); m_charge = 0;
    end
    check_all();
    @(negedge clk);
    fire_ready = 1'b0;
  endtask

  task automatic reset_phase();
    reset_n    = 1'b0;
    fire_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      frame_clk = ~frame_clk;
    end
    model_reset();
    @(negedge clk);
    check_all();
    frame_clk  = 1'b0;
    fire_ready = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0] pool [10] = '{8'd26, 8'd22, 8'd4, 8'd7, 8'd20, 8'd8, 8'd30, 8'd30, 8'd31, 8'd0};

  initial begin
    logic [7:0] k;
    int         len;
    frame_clk  = 1'b0;
    keycode    = 8'd26;
    controls   = P1;
    fire_ready = 1'b0;
    model_reset();
    reset_phase();

    // First tick after reset: up held and pressed, then held only.
    frame(8'd26); frame(8'd26); frame(8'd0);

    // Decode with the second map, including an empty slot vs keycode 0.
    controls = P2;
    frame(8'd15); frame(8'd0); frame(8'd40); frame(8'd0);
    controls = P1;

    // Charge 10, release, wait with ready low, accept, ride out cooldown.
    repeat (10) frame(8'd30);
    frame(8'd0);
    repeat (5) frame(8'd0);
    accept();
    repeat (31) frame(8'd0);

    // Saturation then replacement by another key.
    repeat (100) frame(8'd30);
    frame(8'd26);
    accept();

    // Fire pressed during cooldown and held past its end must not charge.
    repeat (3) frame(8'd0);
    repeat (32) frame(8'd30);
    frame(8'd0);
    frame(8'd30); frame(8'd30);
    frame(8'd0);
    accept();
    repeat (31) frame(8'd0);

    // Long hold of left (auto-repeat when enabled).
    repeat (32) frame(8'd4);
    frame(8'd0);

    // Randomized key runs with random handshake attempts.
    for (int r = 0; r < 60; r++) begin
      k   = pool[$urandom_range(0, 9)];
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        frame(k);
        if ($urandom_range(0, 3) == 0) accept();
      end
    end

    // Reset while a launch is pending, with ready and frame activity present.
    repeat (3) frame(8'd30);
    frame(8'd0);
    reset_phase();
    frame(8'd0);
    frame(8'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/player_input.md
# player_input

Per-player input conditioner. It sits between the keycode byte that the SoC exports for one player and that player's movement/bomb logic. It decodes the raw USB keycode against the player's 64-bit control map and aligns all decoded actions to the frame tick. It also produces held levels and one-frame press pulses, and runs the bomb charge/fire/cooldown state machine with a valid/ready handshake toward the player block. One instance per player; the two instances are identical apart from the `controls` input.

## Interface
Parameters:
- CHARGE_W, 6, width of charge counter and `fire_power`
- MAX_CHARGE, 63, saturation value of charge (≤ 2^CHARGE_W−1)
- COOLDOWN_FRAMES, 30, frames locked out after a fire is accepted
- REPEAT_DELAY, 20, frames a key is held before the first auto-repeat pulse
- REPEAT_PERIOD, 4, frames between later auto-repeat pulses

Ports:
- clk  in  1  system clock (50 MHz); only clock
- reset_n  in  1  synchronous, active-low reset
- frame_clk  in  1  vertical sync from the VGA controller, clk-domain level
- keycode  in  8  current keycode for this player; 0 = no key
- controls  in  64  control map; slot i = controls[8i+7:8i]; i=7 up, 6 down, 5 left, 4 right, 3 aim-left, 2 aim-right, 1 fire, 0 alt
- held  out  8  action i currently held (frame-aligned)
- pressed  out  8  action i newly pressed this frame
- charging  out  1  fire key held and charge accumulating
- charge  out  CHARGE_W  current charge level
- fire_valid  out  1  bomb launch request pending
- fire_power  out  CHARGE_W  charge captured at release; stable while fire_valid
- fire_ready  in  1  player block accepts the launch
- cooldown  out  1  fire locked out

## Operation
- Frame tick: frame_clk passes through a 2-flop synchronizer. `tick` is a 1-clk pulse on its rising edge.
- Decode (combinational, every clk): raw[i] = (keycode != 0) && (keycode == slot i). Duplicate slots may match simultaneously.
- On tick: held ← raw; prev ← held; pressed ← raw & ~held. pressed therefore stays high for exactly one frame (until the next tick).
- Charge FSM (states IDLE, CHARGE, FIRE, COOLDOWN). All transitions occur only on tick except FIRE→COOLDOWN.
  - IDLE: on tick with pressed-edge of fire (raw[1] & ~held[1]) → CHARGE, charge ← 1.
  - CHARGE: on tick, if raw[1], charge ← min(charge+1, MAX_CHARGE). If ~raw[1] (release, or a different key replaces fire): fire_power ← charge, → FIRE.
  - FIRE: fire_valid=1. Charge is frozen. Ticks are ignored. On the clk cycle with fire_valid & fire_ready → COOLDOWN, count ← COOLDOWN_FRAMES, charge ← 0.
  - COOLDOWN: count decrements per tick; at 0 → IDLE. A fire key still held on return does not restart charging; a new press edge is required.
- charging = (state==CHARGE); cooldown = (state==COOLDOWN).
- Reset: all outputs 0, state IDLE, synchronizer flops 0. Reset has priority over tick and handshake in the same cycle.

## Timing
- Tick asserted 3 clk after the frame_clk rising edge (2 sync + edge register). held/pressed/charge update on the clk after tick.
- fire_valid rises 1 clk after the release tick. Acceptance takes effect on the clk edge where fire_valid&fire_ready; fire_valid is low on the next cycle.
- fire_ready high while fire_valid is low has no effect. fire_power and fire_valid do not change until accepted.
- Charge saturates and never wraps. The count in COOLDOWN_FRAMES=0 case returns to IDLE on the first tick.

## Configuration
- PLAYER_INPUT_AUTOREPEAT_EN defined: for actions 7..2, a per-action frame counter runs while held. pressed[i] also pulses for one frame after REPEAT_DELAY held frames, then every REPEAT_PERIOD frames. Release clears the counter. Fire (1) and alt (0) never repeat.
- Undefined: pressed is the edge only; no repeat counters are synthesized.

## Test plan
- Reset: reset_n=0 with keycode=26 and frame_clk toggling → all outputs 0; after release, first tick gives held[7]=1, pressed[7]=1 for one frame, then held only.
- Decode: P2 map, keycode=15 → held[4] only. keycode=0 with a slot of 0 in controls → held=0.
- Charge: hold fire (30) for 10 ticks, release → fire_valid=1, fire_power=10. With fire_ready held low 5 frames, fire_power is stable. Pulsing ready → cooldown=1 for 30 ticks, then IDLE.
- Saturation/replace: hold fire 100 ticks → charge=63. Switch keycode to 26 → FIRE with fire_power=63, and pressed[7]=1 on that tick.
- Lockout: press fire during COOLDOWN and keep it held through cooldown end → charging stays 0 until release and re-press.
- PLAYER_INPUT_AUTOREPEAT_EN: hold keycode 4 for 32 frames → pressed[5] pulses at frames 1, 21, 25, 29.
